// File: rtl/spfp_fu_req_pkg.sv
// Shared types for the SPFPFU request path: op/select encodings, request FSM states, watchdog default.
package spfp_fu_req_pkg;

  typedef enum logic [3:0] {
    F_LW   = 4'd0,
    F_SW   = 4'd1,
    F_ADD  = 4'd2,
    F_SUB  = 4'd3,
    F_MUL  = 4'd4,
    F_DIV  = 4'd5,
    F_SQRT = 4'd6,
    F_MIN  = 4'd7,
    F_MAX  = 4'd8,
    F_MV   = 4'd9
  } SPFP_OP_TYPE;

  typedef enum logic [1:0] {
    FM_RS1  = 2'd0,
    FM_RS2  = 2'd1,
    FM_IMM  = 2'd2,
    FM_ZERO = 2'd3
  } SPFP_SEL_TYPE;

  typedef enum logic [1:0] {
    SR_IDLE = 2'd0,
    SR_BUSY = 2'd1,
    SR_HOLD = 2'd2
  } SPFP_REQ_STATE;

  localparam int SPFP_TIMEOUT_CYC = 64;

endpackage

// File: rtl/spfp_fu_req_if.sv
// SPFPFU request bundle: decode-side request, FU bus and result handshake.
// master = spfp_fu_req side, slave = the surrounding pipeline / FU.
interface spfp_fu_req_if
  import spfp_fu_req_pkg::*;
#(
  parameter int FLEN  = 32,
  parameter int PC_SZ = 32
) ();
  logic             in_valid;
  logic             in_ready;
  SPFP_OP_TYPE      in_op;
  SPFP_SEL_TYPE     in_sel_x;
  SPFP_SEL_TYPE     in_sel_y;
  logic [FLEN-1:0]  in_Fs1_data;
  logic [FLEN-1:0]  in_Fs2_data;
  logic [FLEN-1:0]  in_imm;
  logic [PC_SZ-1:0] in_pc;

  logic             fu_start;
  SPFP_OP_TYPE      fu_op;
  SPFP_SEL_TYPE     fu_sel_x;
  SPFP_SEL_TYPE     fu_sel_y;
  logic [FLEN-1:0]  fu_Fs1_data;
  logic [FLEN-1:0]  fu_Fs2_data;
  logic [FLEN-1:0]  fu_imm;
  logic             fu_done;
  logic [FLEN-1:0]  fu_Fd_data;
  logic [FLEN-1:0]  fu_ls_addr;
  logic [FLEN-1:0]  fu_st_data;
  logic             fu_mis;

  logic             out_valid;
  logic             out_ready;
  logic [FLEN-1:0]  out_Fd_data;
  logic [FLEN-1:0]  out_ls_addr;
  logic [FLEN-1:0]  out_st_data;
  logic             out_mis;
  SPFP_OP_TYPE      out_op;
  logic [PC_SZ-1:0] out_pc;
  logic             out_timeout;

  modport master (
    input  in_valid, in_op, in_sel_x, in_sel_y, in_Fs1_data, in_Fs2_data, in_imm, in_pc,
    output in_ready,
    output fu_start, fu_op, fu_sel_x, fu_sel_y, fu_Fs1_data, fu_Fs2_data, fu_imm,
    input  fu_done, fu_Fd_data, fu_ls_addr, fu_st_data, fu_mis,
    output out_valid, out_Fd_data, out_ls_addr, out_st_data, out_mis, out_op, out_pc, out_timeout,
    input  out_ready
  );

  modport slave (
    output in_valid, in_op, in_sel_x, in_sel_y, in_Fs1_data, in_Fs2_data, in_imm, in_pc,
    input  in_ready,
    input  fu_start, fu_op, fu_sel_x, fu_sel_y, fu_Fs1_data, fu_Fs2_data, fu_imm,
    output fu_done, fu_Fd_data, fu_ls_addr, fu_st_data, fu_mis,
    input  out_valid, out_Fd_data, out_ls_addr, out_st_data, out_mis, out_op, out_pc, out_timeout,
    output out_ready
  );
endinterface

// File: rtl/spfp_fu_req_wdog.sv
// spfp_wdog: saturating BUSY-cycle counter; the timeout compare exists only with SPFP_TIMEOUT_EN.
module spfp_wdog #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic busy,
  output logic timeout
);
  logic [7:0] cnt_r;

  // count BUSY cycles, cleared on accept, parks at 255
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= 8'd0;
    end else if (clr) begin
      cnt_r <= 8'd0;
    end else if (busy && (cnt_r != 8'hFF)) begin
      cnt_r <= cnt_r + 8'd1;
    end
  end

`ifdef SPFP_TIMEOUT_EN
  // cnt_r counts completed BUSY cycles, so the current cycle is the TIMEOUT_CYC-th at LIMIT
  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYC - 1);
  assign timeout = busy && (cnt_r >= LIMIT);
`else
  logic unused_limit_s;
  assign unused_limit_s = ^(8'(TIMEOUT_CYC)) ^ ^cnt_r;
  assign timeout = 1'b0;
`endif
endmodule

// File: rtl/spfp_fu_req.sv
// SPFPFU request master: registers one FP op onto the FU bus, holds it until done, buffers the result.
// Optional watchdog completion is enabled by defining SPFP_TIMEOUT_EN.
module spfp_fu_req
  import spfp_fu_req_pkg::*;
#(
  parameter int FLEN        = 32,
  parameter int PC_SZ       = 32,
  parameter int TIMEOUT_CYC = SPFP_TIMEOUT_CYC
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          flush_in,
  spfp_fu_req_if.master bus
);
  localparam logic [1:0] ST_IDLE = SR_IDLE;
  localparam logic [1:0] ST_BUSY = SR_BUSY;
  localparam logic [1:0] ST_HOLD = SR_HOLD;

  logic [1:0]       state_r;
  logic             up_r;
  logic [PC_SZ-1:0] pc_r;
  logic             busy_s;
  logic             accept_s;
  logic             done_s;
  logic             timeout_s;

  assign busy_s      = (state_r == ST_BUSY);
  // up_r keeps in_ready low for the first cycle after reset release
  assign bus.in_ready = up_r && (state_r == ST_IDLE) && !flush_in;
  assign accept_s    = bus.in_valid && bus.in_ready;
  assign done_s      = busy_s && bus.fu_start && bus.fu_done;

  spfp_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk_in),
    .rst     (reset_in),
    .clr     (accept_s),
    .busy    (busy_s),
    .timeout (timeout_s)
  );

  // request FSM with start / result-valid flags
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_r       <= ST_IDLE;
      up_r          <= 1'b0;
      bus.fu_start  <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      up_r <= 1'b1;
      if (flush_in) begin
        state_r       <= ST_IDLE;
        bus.fu_start  <= 1'b0;
        bus.out_valid <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (accept_s) begin
              state_r      <= ST_BUSY;
              bus.fu_start <= 1'b1;
            end
          end
          ST_BUSY: begin
            if (done_s || timeout_s) begin
              state_r       <= ST_HOLD;
              bus.fu_start  <= 1'b0;
              bus.out_valid <= 1'b1;
            end
          end
          ST_HOLD: begin
            if (bus.out_ready) begin
              state_r       <= ST_IDLE;
              bus.out_valid <= 1'b0;
            end
          end
          default: begin
            state_r       <= ST_IDLE;
            bus.fu_start  <= 1'b0;
            bus.out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  // request fields are loaded only on accept, so they stay frozen while fu_start is high
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bus.fu_op       <= F_LW;
      bus.fu_sel_x    <= FM_RS1;
      bus.fu_sel_y    <= FM_RS1;
      bus.fu_Fs1_data <= {FLEN{1'b0}};
      bus.fu_Fs2_data <= {FLEN{1'b0}};
      bus.fu_imm      <= {FLEN{1'b0}};
      pc_r            <= {PC_SZ{1'b0}};
    end else if (accept_s) begin
      bus.fu_op       <= bus.in_op;
      bus.fu_sel_x    <= bus.in_sel_x;
      bus.fu_sel_y    <= bus.in_sel_y;
      bus.fu_Fs1_data <= bus.in_Fs1_data;
      bus.fu_Fs2_data <= bus.in_Fs2_data;
      bus.fu_imm      <= bus.in_imm;
      pc_r            <= bus.in_pc;
    end
  end

  // result capture; a real done beats a same-cycle watchdog expiry, flush discards both
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bus.out_Fd_data <= {FLEN{1'b0}};
      bus.out_ls_addr <= {FLEN{1'b0}};
      bus.out_st_data <= {FLEN{1'b0}};
      bus.out_mis     <= 1'b0;
      bus.out_op      <= F_LW;
      bus.out_pc      <= {PC_SZ{1'b0}};
      bus.out_timeout <= 1'b0;
    end else if (!flush_in && done_s) begin
      bus.out_Fd_data <= bus.fu_Fd_data;
      bus.out_ls_addr <= bus.fu_ls_addr;
      bus.out_st_data <= bus.fu_st_data;
      bus.out_mis     <= bus.fu_mis;
      bus.out_op      <= bus.fu_op;
      bus.out_pc      <= pc_r;
      bus.out_timeout <= 1'b0;
    end else if (!flush_in && timeout_s) begin
      bus.out_Fd_data <= {FLEN{1'b0}};
      bus.out_ls_addr <= {FLEN{1'b0}};
      bus.out_st_data <= {FLEN{1'b0}};
      bus.out_mis     <= 1'b0;
      bus.out_op      <= bus.fu_op;
      bus.out_pc      <= pc_r;
      bus.out_timeout <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spfp_fu_req.sv
// Self-checking bench for spfp_fu_req: directed vector table, random ops vs a reference model,
// and hand-written flush / reset / watchdog sequences (watchdog expectations follow SPFP_TIMEOUT_EN).
module tb_spfp_fu_req;
  import spfp_fu_req_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  spfp_fu_req_if #(.FLEN(32), .PC_SZ(32)) bus ();

  spfp_fu_req #(.FLEN(32), .PC_SZ(32), .TIMEOUT_CYC(8)) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .flush_in (flush),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] fd;
    logic [31:0] addr;
    logic [31:0] st;
    logic        mis;
  } res_t;

  typedef struct {
    SPFP_OP_TYPE  op;
    SPFP_SEL_TYPE sx;
    SPFP_SEL_TYPE sy;
    logic [31:0]  fs1;
    logic [31:0]  fs2;
    logic [31:0]  imm;
    logic [31:0]  pc;
    int           lat;
    int           rdly;
    logic [31:0]  e_fd;
    logic [31:0]  e_addr;
    logic [31:0]  e_st;
    logic         e_mis;
  } vec_t;

  // Functional model of the FU: address = x + y, store data = Fs2, word misalignment for LW/SW
  function automatic logic [31:0] pick(SPFP_SEL_TYPE s, logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    case (s)
      FM_RS1:  return a;
      FM_RS2:  return b;
      FM_IMM:  return imm;
      default: return 32'd0;
    endcase
  endfunction

  function automatic res_t fu_model(SPFP_OP_TYPE op, SPFP_SEL_TYPE sx, SPFP_SEL_TYPE sy,
                                    logic [31:0] a, logic [31:0] b, logic [31:0] imm);
    res_t r;
    r.addr = pick(sx, a, b, imm) + pick(sy, a, b, imm);
    r.st   = b;
    r.fd   = (op == F_DIV) ? 32'h3F80_0000 : (a ^ b);
    r.mis  = ((op == F_LW) || (op == F_SW)) && (r.addr[1:0] != 2'd0);
    return r;
  endfunction

  // FU stub driven from the DUT's bus outputs; done after stub_lat cycles of fu_start
  int   stub_lat = 1;
  logic stub_en  = 1'b1;
  logic stray    = 1'b0;
  int   stub_cnt;
  res_t stub_r;

  always_ff @(posedge clk) stub_cnt <= bus.fu_start ? stub_cnt + 1 : 0;
  always_comb stub_r = fu_model(bus.fu_op, bus.fu_sel_x, bus.fu_sel_y, bus.fu_Fs1_data, bus.fu_Fs2_data, bus.fu_imm);
  assign bus.fu_done    = stray || (stub_en && bus.fu_start && (stub_cnt == stub_lat - 1));
  assign bus.fu_Fd_data = stub_r.fd;
  assign bus.fu_ls_addr = stub_r.addr;
  assign bus.fu_st_data = stub_r.st;
  assign bus.fu_mis     = stub_r.mis;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    bus.in_valid    = 1'b1;
    bus.in_op       = v.op;
    bus.in_sel_x    = v.sx;
    bus.in_sel_y    = v.sy;
    bus.in_Fs1_data = v.fs1;
    bus.in_Fs2_data = v.fs2;
    bus.in_imm      = v.imm;
    bus.in_pc       = v.pc;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int   n;
    logic stable;
    logic held;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({nm, " in_ready"}, 64'(bus.in_ready), 64'(1));
    stub_lat      = v.lat;
    drive(v);
    bus.out_ready = (v.rdly == 0);
    tick();
    bus.in_valid    = 1'b0;
    bus.in_Fs1_data = $urandom();
    bus.in_Fs2_data = $urandom();
    bus.in_imm      = $urandom();
    bus.in_pc       = $urandom();
    chk({nm, " start"}, 64'(bus.fu_start), 64'(1));
    n      = 0;
    stable = 1'b1;
    while (bus.fu_start && n < 300) begin
      if (bus.fu_op !== v.op || bus.fu_sel_x !== v.sx || bus.fu_sel_y !== v.sy ||
          bus.fu_Fs1_data !== v.fs1 || bus.fu_Fs2_data !== v.fs2 || bus.fu_imm !== v.imm)
        stable = 1'b0;
      n++;
      tick();
    end
    chk({nm, " start_cycles"}, 64'(n), 64'(v.lat));
    chk({nm, " fu_stable"}, 64'(stable), 64'(1));
    chk({nm, " out_valid"}, 64'(bus.out_valid), 64'(1));
    chk({nm, " out_fd"}, 64'(bus.out_Fd_data), 64'(v.e_fd));
    chk({nm, " out_addr"}, 64'(bus.out_ls_addr), 64'(v.e_addr));
    chk({nm, " out_st"}, 64'(bus.out_st_data), 64'(v.e_st));
    chk({nm, " out_mis"}, 64'(bus.out_mis), 64'(v.e_mis));
    chk({nm, " out_op"}, 64'(bus.out_op), 64'(v.op));
    chk({nm, " out_pc"}, 64'(bus.out_pc), 64'(v.pc));
    chk({nm, " out_timeout"}, 64'(bus.out_timeout), 64'(0));
    chk({nm, " busy_no_ready"}, 64'(bus.in_ready), 64'(0));
    held = 1'b1;
    for (int k = 0; k < v.rdly; k++) begin
      if (!bus.out_valid || bus.in_ready || bus.out_Fd_data !== v.e_fd || bus.out_ls_addr !== v.e_addr ||
          bus.out_st_data !== v.e_st || bus.out_mis !== v.e_mis)
        held = 1'b0;
      tick();
    end
    chk({nm, " held"}, 64'(held), 64'(1));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({nm, " out_drop"}, 64'(bus.out_valid), 64'(0));
    chk({nm, " ready_again"}, 64'(bus.in_ready), 64'(1));
  endtask

  vec_t dir[5];
  vec_t v;
  res_t r;
  int   n;

  initial begin
    dir[0] = '{F_LW,  FM_RS1, FM_IMM,  32'h0000_1000, 32'h0000_0000, 32'h0000_0004, 32'h0000_0100, 1, 0,
               32'h0000_1000, 32'h0000_1004, 32'h0000_0000, 1'b0};
    dir[1] = '{F_SW,  FM_RS1, FM_IMM,  32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0002, 32'h0000_0104, 1, 5,
               32'hDEAD_AEEF, 32'h0000_1002, 32'hDEAD_BEEF, 1'b1};
    dir[2] = '{F_DIV, FM_RS1, FM_RS2,  32'h4000_0000, 32'h4080_0000, 32'h0000_0000, 32'h0000_0108, 10, 1,
               32'h3F80_0000, 32'h8080_0000, 32'h4080_0000, 1'b0};
    dir[3] = '{F_ADD, FM_RS2, FM_ZERO, 32'h1234_5678, 32'h0000_0003, 32'h0000_FFFF, 32'h0000_010C, 3, 2,
               32'h1234_567B, 32'h0000_0003, 32'h0000_0003, 1'b0};
    dir[4] = '{F_LW,  FM_IMM, FM_ZERO, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0110, 1, 0,
               32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};

    rst   = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_op = F_LW; bus.in_sel_x = FM_RS1; bus.in_sel_y = FM_RS1;
    bus.in_Fs1_data = 32'd0; bus.in_Fs2_data = 32'd0; bus.in_imm = 32'd0; bus.in_pc = 32'd0;
    #2;
    chk("rst in_ready", 64'(bus.in_ready), 64'(0));
    chk("rst fu_start", 64'(bus.fu_start), 64'(0));
    chk("rst out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst out_fd", 64'(bus.out_Fd_data), 64'(0));
    chk("rst fu_fs1", 64'(bus.fu_Fs1_data), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    chk("up in_ready", 64'(bus.in_ready), 64'(1));

    for (int i = 0; i < 5; i++) run_vec(dir[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 20; i++) begin
      v.op   = SPFP_OP_TYPE'(4'($urandom_range(0, 9)));
      v.sx   = SPFP_SEL_TYPE'(2'($urandom_range(0, 3)));
      v.sy   = SPFP_SEL_TYPE'(2'($urandom_range(0, 3)));
      v.fs1  = $urandom(); v.fs2 = $urandom(); v.imm = $urandom(); v.pc = $urandom();
      v.lat  = ((v.op == F_LW) || (v.op == F_SW)) ? 1 : int'($urandom_range(1, 6));
      v.rdly = int'($urandom_range(0, 3));
      r = fu_model(v.op, v.sx, v.sy, v.fs1, v.fs2, v.imm);
      v.e_fd = r.fd; v.e_addr = r.addr; v.e_st = r.st; v.e_mis = r.mis;
      run_vec(v, $sformatf("rnd%0d", i));
    end

    // flush on the third BUSY cycle, then a stray late done
    stub_lat = 10;
    drive(dir[2]);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush fu_start", 64'(bus.fu_start), 64'(0));
    chk("flush out_valid", 64'(bus.out_valid), 64'(0));
    stray = 1'b1;
    tick();
    tick();
    stray = 1'b0;
    chk("late_done out_valid", 64'(bus.out_valid), 64'(0));
    chk("late_done fu_start", 64'(bus.fu_start), 64'(0));
    run_vec(dir[3], "after_flush");

    // flush together with fu_done: result dropped
    stub_lat = 3;
    drive(dir[3]);
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_done out_valid", 64'(bus.out_valid), 64'(0));
    chk("flush_done fu_start", 64'(bus.fu_start), 64'(0));
    tick();
    chk("flush_done out_valid2", 64'(bus.out_valid), 64'(0));

    // in_valid and flush together: no accept
    drive(dir[0]);
    flush = 1'b1;
    #1;
    chk("flush_req in_ready", 64'(bus.in_ready), 64'(0));
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_req fu_start", 64'(bus.fu_start), 64'(0));
    tick();
    chk("flush_req fu_start2", 64'(bus.fu_start), 64'(0));

    // async reset while holding a result
    stub_lat = 1;
    bus.out_ready = 1'b0;
    drive(dir[0]);
    tick();
    bus.in_valid = 1'b0;
    tick();
    chk("hold out_valid", 64'(bus.out_valid), 64'(1));
    rst = 1'b1;
    #1;
    chk("arst out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst in_ready", 64'(bus.in_ready), 64'(0));
    chk("arst out_addr", 64'(bus.out_ls_addr), 64'(0));
    #2;
    rst = 1'b0;
    tick();
    chk("arst recover in_ready", 64'(bus.in_ready), 64'(1));

    // FU never answers
    stub_en = 1'b0;
    drive(dir[2]);
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.fu_start && n < 100) begin
      n++;
      tick();
    end
`ifdef SPFP_TIMEOUT_EN
    chk("wdog busy_cycles", 64'(n), 64'(8));
    chk("wdog out_valid", 64'(bus.out_valid), 64'(1));
    chk("wdog out_timeout", 64'(bus.out_timeout), 64'(1));
    chk("wdog out_fd", 64'(bus.out_Fd_data), 64'(0));
    chk("wdog out_addr", 64'(bus.out_ls_addr), 64'(0));
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("wdog out_drop", 64'(bus.out_valid), 64'(0));
`else
    chk("nowdog busy_cycles", 64'(n), 64'(100));
    chk("nowdog fu_start", 64'(bus.fu_start), 64'(1));
    chk("nowdog out_valid", 64'(bus.out_valid), 64'(0));
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("nowdog flush", 64'(bus.fu_start), 64'(0));
`endif
    stub_en = 1'b1;
    run_vec(dir[1], "final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
